// File: rtl/cpu_pkg.sv
// Shared CPU definitions: result widths, functional-unit ids and the CDB entry payload.
package cpu_pkg;

  localparam int unsigned ROB_IDX_W = 4;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FU_ID_W   = 2;

  // Functional-unit ids; these double as requester numbers on the CDB arbiter.
  localparam logic [FU_ID_W-1:0] FU_BRANCH = 2'd0;
  localparam logic [FU_ID_W-1:0] FU_LSU    = 2'd1;
  localparam logic [FU_ID_W-1:0] FU_FXU1   = 2'd2;
  localparam logic [FU_ID_W-1:0] FU_FXU0   = 2'd3;

  // One completed result waiting for (or riding on) the common data bus.
  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    value;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-producer result queue in front of the CDB arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write din (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   flush      : empty the queue; wins over push and pop
//   din        : entry to write
//   dout       : current head entry (valid when count != 0)
//   count      : number of stored entries, 0..DEPTH
module cdb_result_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  cdb_entry_t                 din,
  output cdb_entry_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cdb_entry_t       mem_q [DEPTH];
  cdb_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointer/count bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Shares NUM_LANES common-data-bus lanes among NUM_REQ result producers
// (0=branch, 1=LSU, 2=FXU1, 3=FXU0). Each producer has a small result queue;
// a round-robin scheduler drains queue heads onto registered CDB lanes.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : squash everything queued or about to broadcast
//   req_valid    : producer r presents {req_rob_idx, req_value} slice r
//   req_ready    : queue r has space (from registered count only)
//   cdb_valid    : lane l broadcasts this cycle
//   cdb_rob_idx  : ROB index per lane
//   cdb_value    : result value per lane
//   cdb_src      : requester id driving each lane
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned QDEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]    req_rob_idx,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_LANES-1:0]        cdb_valid,
  output logic [NUM_LANES*IDX_W-1:0]  cdb_rob_idx,
  output logic [NUM_LANES*DATA_W-1:0] cdb_value,
  output logic [NUM_LANES*2-1:0]      cdb_src
);

  import cpu_pkg::cdb_entry_t;
  import cpu_pkg::ROB_IDX_W;
  import cpu_pkg::FU_ID_W;

  localparam int unsigned RR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W   = $clog2(QDEPTH + 1);
  localparam int unsigned E_VAL_W = cpu_pkg::DATA_W;

  cdb_entry_t          fifo_din  [NUM_REQ];
  cdb_entry_t          fifo_dout [NUM_REQ];
  logic [CNT_W-1:0]    fifo_cnt  [NUM_REQ];
  logic [NUM_REQ-1:0]  push_c;
  logic [NUM_REQ-1:0]  pop_c;
  logic [NUM_REQ-1:0]  nonempty_c;
  logic [NUM_REQ-1:0]  taken_c;
  logic [NUM_LANES-1:0] lane_hit_c;
  logic [RR_W-1:0]     lane_sel_c [NUM_LANES];
  logic [RR_W-1:0]     scan_c;

  logic [RR_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_LANES-1:0]        cdb_valid_q, cdb_valid_d;
  logic [NUM_LANES*IDX_W-1:0]  cdb_rob_idx_q, cdb_rob_idx_d;
  logic [NUM_LANES*DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [NUM_LANES*2-1:0]      cdb_src_q, cdb_src_d;

  // One result queue per producer; ready depends on the registered count alone.
  for (genvar r = 0; r < int'(NUM_REQ); r++) begin : g_req
    assign req_ready[r]  = (fifo_cnt[r] != CNT_W'(QDEPTH));
    assign nonempty_c[r] = (fifo_cnt[r] != '0);
    assign push_c[r]     = req_valid[r] & req_ready[r] & ~flush;
    assign fifo_din[r]   = '{rob_idx: ROB_IDX_W'(req_rob_idx[r*IDX_W +: IDX_W]),
                             value:   E_VAL_W'(req_value[r*DATA_W +: DATA_W])};

    cdb_result_fifo #(
      .DEPTH (QDEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c[r]),
      .pop   (pop_c[r]),
      .flush (flush),
      .din   (fifo_din[r]),
      .dout  (fifo_dout[r]),
      .count (fifo_cnt[r])
    );
  end

  // Round-robin pick: lane l takes the l-th non-empty queue scanning from rr_ptr.
  // Each lane rescans but skips queues already granted, so a queue wins at most once.
  always_comb begin
    pop_c      = '0;
    taken_c    = '0;
    lane_hit_c = '0;
    scan_c     = '0;
    rr_ptr_d   = rr_ptr_q;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      lane_sel_c[l] = '0;
    end
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        scan_c = RR_W'((32'(rr_ptr_q) + i) % NUM_REQ);
        if (!lane_hit_c[l] && nonempty_c[scan_c] && !taken_c[scan_c]) begin
          lane_hit_c[l]   = 1'b1;
          lane_sel_c[l]   = scan_c;
          taken_c[scan_c] = 1'b1;
          // Later lanes overwrite, so this ends as last granted + 1.
          rr_ptr_d = RR_W'((32'(scan_c) + 32'd1) % NUM_REQ);
        end
      end
    end
    pop_c = taken_c;
    // Flush squashes the pick entirely and leaves the pointer where it was.
    if (flush) begin
      pop_c    = '0;
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Next lane contents; unused lanes are driven to all-zero.
  always_comb begin
    cdb_valid_d   = '0;
    cdb_rob_idx_d = '0;
    cdb_value_d   = '0;
    cdb_src_d     = '0;
    if (!flush) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (lane_hit_c[l]) begin
          cdb_valid_d[l]                   = 1'b1;
          cdb_rob_idx_d[l*IDX_W +: IDX_W]  = IDX_W'(fifo_dout[lane_sel_c[l]].rob_idx);
          cdb_value_d[l*DATA_W +: DATA_W]  = DATA_W'(fifo_dout[lane_sel_c[l]].value);
          cdb_src_d[l*FU_ID_W +: FU_ID_W]  = FU_ID_W'(lane_sel_c[l]);
        end
      end
    end
  end

  // Output lanes and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      cdb_valid_q   <= '0;
      cdb_rob_idx_q <= '0;
      cdb_value_q   <= '0;
      cdb_src_q     <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_idx_q <= cdb_rob_idx_d;
      cdb_value_q   <= cdb_value_d;
      cdb_src_q     <= cdb_src_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_idx = cdb_rob_idx_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed + sustained-traffic bench for cdb_arbiter with a result scoreboard.
module tb_cdb_arbiter;

  localparam int NR = 4;
  localparam int NL = 2;
  localparam int IW = 4;
  localparam int DW = 16;
  localparam int QD = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [NR-1:0]    req_valid;
  logic [NR*IW-1:0] req_rob_idx;
  logic [NR*DW-1:0] req_value;
  logic [NR-1:0]    req_ready;
  logic [NL-1:0]    cdb_valid;
  logic [NL*IW-1:0] cdb_rob_idx;
  logic [NL*DW-1:0] cdb_value;
  logic [NL*2-1:0]  cdb_src;

  cdb_arbiter #(
    .NUM_REQ(NR), .NUM_LANES(NL), .IDX_W(IW), .DATA_W(DW), .QDEPTH(QD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_rob_idx (req_rob_idx),
    .req_value   (req_value),
    .req_ready   (req_ready),
    .cdb_valid   (cdb_valid),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_value   (cdb_value),
    .cdb_src     (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    src;
    logic [IW-1:0] idx;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] cur_idx [NR];
  logic [DW-1:0] cur_val [NR];
  logic [NR-1:0] acc_mask;
  int            last_grant [NR];
  int            cyc;
  bit            fair_en;
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pend(input int r);
    int c;
    c = 0;
    foreach (sb[i]) if (int'(sb[i].src) == r) c++;
    return c;
  endfunction

  // Pop the oldest pending result of each broadcasting source and compare.
  task automatic check_lanes();
    for (int l = 0; l < NL; l++) begin
      logic [1:0]    s;
      logic [IW-1:0] oi;
      logic [DW-1:0] ov;
      int            k;
      s  = cdb_src[l*2 +: 2];
      oi = cdb_rob_idx[l*IW +: IW];
      ov = cdb_value[l*DW +: DW];
      if (cdb_valid[l]) begin
        k = -1;
        for (int i = 0; i < sb.size(); i++) if (k < 0 && sb[i].src == s) k = i;
        chk("lane_has_pending", 32'(k >= 0), 32'd1);
        if (k >= 0) begin
          chk("lane_idx", 32'(oi), 32'(sb[k].idx));
          chk("lane_val", 32'(ov), 32'(sb[k].val));
          sb.delete(k);
        end
        last_grant[s] = cyc;
      end else begin
        chk("idle_lane_zero", 32'({s, oi, ov}), 32'd0);
      end
    end
  endtask

  // One clock: drive at +1 after a rising edge, sample at +1 after the next.
  task automatic step(input logic [NR-1:0] v, input logic fl);
    logic [NR-1:0] acc;
    acc = '0;
    for (int r = 0; r < NR; r++) begin
      req_rob_idx[r*IW +: IW] = cur_idx[r];
      req_value[r*DW +: DW]   = cur_val[r];
      if (v[r] && !fl && pend(r) < QD) acc[r] = 1'b1;
    end
    req_valid = v;
    flush     = fl;
    @(posedge clk);
    #1;
    cyc++;
    if (fl) sb.delete();
    check_lanes();
    for (int r = 0; r < NR; r++) begin
      if (acc[r]) sb.push_back('{src: 2'(r), idx: cur_idx[r], val: cur_val[r]});
    end
    for (int r = 0; r < NR; r++) chk("req_ready", 32'(req_ready[r]), 32'(pend(r) < QD));
    if (fair_en) begin
      for (int r = 0; r < NR; r++) chk("fair_gap", 32'((cyc - last_grant[r]) <= 1), 32'd1);
    end
    acc_mask  = acc;
    req_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic regen(input logic [NR-1:0] m);
    for (int r = 0; r < NR; r++) begin
      if (m[r]) begin
        cur_idx[r] = 4'($urandom);
        cur_val[r] = 16'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) step('0, 1'b0);
    chk("drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_full;
    int   t;
    n_vec = 0; n_err = 0; cyc = 0; fair_en = 1'b0;
    rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_rob_idx = '0; req_value = '0;
    for (int r = 0; r < NR; r++) begin
      cur_idx[r] = '0; cur_val[r] = '0; last_grant[r] = 0;
    end

    // Reset state
    #3;
    chk("rst_valid", 32'(cdb_valid), 32'd0);
    chk("rst_idx",   32'(cdb_rob_idx), 32'd0);
    chk("rst_val",   32'(cdb_value), 32'd0);
    chk("rst_src",   32'(cdb_src), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single LSU result, one cycle of latency past the accepting edge
    cur_idx[1] = 4'd5; cur_val[1] = 16'h00AA;
    step(4'b0010, 1'b0);
    chk("t1_no_bypass", 32'(cdb_valid), 32'd0);
    step('0, 1'b0);
    chk("t1_valid", 32'(cdb_valid), 32'b01);
    chk("t1_src",   32'(cdb_src[1:0]), 32'd1);
    chk("t1_idx",   32'(cdb_rob_idx[3:0]), 32'd5);
    chk("t1_val",   32'(cdb_value[15:0]), 32'h00AA);
    step('0, 1'b0);
    chk("t1_one_cycle", 32'(cdb_valid), 32'd0);

    // 2: all four at once from rr_ptr=0
    do_reset();
    for (int r = 0; r < NR; r++) begin
      cur_idx[r] = 4'(r + 1); cur_val[r] = 16'(16'h1000 + r);
    end
    step(4'b1111, 1'b0);
    chk("t2_no_bypass", 32'(cdb_valid), 32'd0);
    step('0, 1'b0);
    chk("t2_valid_a", 32'(cdb_valid), 32'b11);
    chk("t2_src_a",   32'(cdb_src), 32'b01_00);
    step('0, 1'b0);
    chk("t2_valid_b", 32'(cdb_valid), 32'b11);
    chk("t2_src_b",   32'(cdb_src), 32'b11_10);
    step('0, 1'b0);
    chk("t2_idle", 32'(cdb_valid), 32'd0);
    // rr_ptr back at 0: branch must precede FXU0
    cur_idx[0] = 4'd6; cur_val[0] = 16'h0606;
    cur_idx[3] = 4'd7; cur_val[3] = 16'h0707;
    step(4'b1001, 1'b0);
    step('0, 1'b0);
    chk("t2_rr_src", 32'(cdb_src), 32'b11_00);

    // 3: FXU0 alone, four results held until accepted
    for (int k = 0; k < 4; k++) begin
      cur_idx[3] = 4'(8 + k); cur_val[3] = 16'(16'hF000 + k);
      t = 0;
      do begin
        step(4'b1000, 1'b0);
        t++;
      end while (!acc_mask[3] && t < 10);
      chk("t3_accept", 32'(acc_mask[3]), 32'd1);
    end
    drain();

    // 3b: all producers saturate, FXU0 queue must fill
    seen_full = 1'b0;
    regen(4'b1111);
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 1'b0);
      regen(acc_mask);
      if (!req_ready[3]) seen_full = 1'b1;
    end
    chk("t3_full_seen", 32'(seen_full), 32'd1);

    // 4: flush with queues loaded and FXU1 pushing
    cur_idx[2] = 4'hE; cur_val[2] = 16'hF1F1;
    step(4'b0100, 1'b1);
    chk("t4_valid", 32'(cdb_valid), 32'd0);
    chk("t4_ready", 32'(req_ready), 32'hF);
    for (int i = 0; i < 3; i++) begin
      step('0, 1'b0);
      chk("t4_quiet", 32'(cdb_valid), 32'd0);
    end

    // 5: asynchronous reset while lanes are valid
    regen(4'b1111);
    step(4'b1111, 1'b0);
    step('0, 1'b0);
    chk("t5_pre_valid", 32'(cdb_valid), 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(cdb_valid), 32'd0);
    chk("t5_async_data",  32'({cdb_rob_idx, cdb_value, cdb_src}), 32'd0);
    chk("t5_async_ready", 32'(req_ready), 32'hF);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      step('0, 1'b0);
      chk("t5_no_stale", 32'(cdb_valid), 32'd0);
    end

    // 6: sustained traffic with fairness tracking
    for (int r = 0; r < NR; r++) last_grant[r] = cyc;
    regen(4'b1111);
    for (int i = 0; i < 200; i++) begin
      if (i == 4) fair_en = 1'b1;
      step(4'b1111, 1'b0);
      regen(acc_mask);
    end
    fair_en = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
